// File: rtl/tt_mux_pkg.sv
// Shared types and word layout for the project mux controller.
package tt_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        RESET  = 2'd2,
        ACTIVE = 2'd3
    } mux_state_t;

    // Broadcast input word and returned output word widths
    localparam int IW_W = 18;
    localparam int OW_W = 24;

    // Field offsets inside the input word
    localparam int IW_CLK  = 0;
    localparam int IW_RSTN = 1;
    localparam int IW_UI   = 2;
    localparam int IW_UIO  = 10;

    // Field offsets inside the output word
    localparam int OW_UO  = 0;
    localparam int OW_UIO = 8;
    localparam int OW_OE  = 16;

endpackage

// File: rtl/tt_mux_edge_sync.sv
// Two-flop synchronizer for an asynchronous pad, followed by a rising-edge
// detector that produces a single-cycle pulse in the clk domain.
module tt_mux_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronizer chain plus the edge-detect history flop
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign pulse = sync & ~prev;

endmodule

// File: rtl/tt_proj_mux_ctrl.sv
// Chip-side project mux: pulse-driven project selection, enable/reset
// hand-over sequencing, input-word broadcast and output-word return.
// Optional macro TT_MUX_OUT_REG_EN registers the pad outputs (1 clk latency).
module tt_proj_mux_ctrl
    import tt_mux_pkg::*;
#(
    parameter int N_PROJ     = 16,
    parameter int SEL_W      = 4,
    parameter int SETTLE_CYC = 4,
    parameter int RST_CYC    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sel_rst,
    input  logic                   sel_inc,
    input  logic                   user_clk,
    input  logic                   user_rst_n,
    input  logic [7:0]             pad_ui_in,
    input  logic [7:0]             pad_uio_in,
    output logic [IW_W-1:0]        proj_iw,
    output logic [N_PROJ-1:0]      proj_ena,
    input  logic [OW_W*N_PROJ-1:0] proj_ow,
    output logic [7:0]             pad_uo_out,
    output logic [7:0]             pad_uio_out,
    output logic [7:0]             pad_uio_oe,
    output logic [SEL_W-1:0]       sel_idx,
    output logic                   active
);

    localparam int CNT_MAX = (SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic              rst_pulse;
    logic              inc_pulse;
    mux_state_t        state;
    mux_state_t        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [SEL_W-1:0]  sel_next;
    logic              ena_on;
    logic [OW_W-1:0]   slice;

    tt_mux_edge_sync u_rst_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sel_rst),
        .pulse (rst_pulse)
    );

    tt_mux_edge_sync u_inc_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sel_inc),
        .pulse (inc_pulse)
    );

    // State, phase counter and selection registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sel_idx <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            sel_idx <= sel_next;
        end
    end

    // Next state: any select edge restarts the settle phase from scratch
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sel_next   = sel_idx;
        if (rst_pulse || inc_pulse) begin
            if (rst_pulse)
                sel_next = '0;
            else if (sel_idx == SEL_W'(N_PROJ - 1))
                sel_next = '0;
            else
                sel_next = sel_idx + SEL_W'(1);
            state_next = SWITCH;
            cnt_next   = '0;
        end else begin
            case (state)
                SWITCH: begin
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        state_next = RESET;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                RESET: begin
                    if (cnt == CNT_W'(RST_CYC - 1)) begin
                        state_next = ACTIVE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                IDLE, ACTIVE: ;
                default: state_next = IDLE;
            endcase
        end
    end

    assign active = (state == ACTIVE);
    assign ena_on = (state == RESET) || (state == ACTIVE);

    // One-hot enable for the selected project during RESET and ACTIVE
    always_comb begin
        proj_ena = '0;
        for (int unsigned k = 0; k < N_PROJ; k++)
            proj_ena[k] = ena_on && (sel_idx == SEL_W'(k));
    end

    assign proj_iw[IW_CLK]       = user_clk;
    assign proj_iw[IW_RSTN]      = active & user_rst_n;
    assign proj_iw[IW_UI +: 8]   = pad_ui_in;
    assign proj_iw[IW_UIO +: 8]  = pad_uio_in;

    // Output-word select; explicit compare keeps unused indices at zero
    always_comb begin
        slice = '0;
        for (int unsigned k = 0; k < N_PROJ; k++)
            if (sel_idx == SEL_W'(k))
                slice = proj_ow[k*OW_W +: OW_W];
    end

`ifdef TT_MUX_OUT_REG_EN
    // Registered pad outputs, forced low whenever no project is active
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_uo_out  <= '0;
            pad_uio_out <= '0;
            pad_uio_oe  <= '0;
        end else begin
            pad_uo_out  <= active ? slice[OW_UO +: 8]  : '0;
            pad_uio_out <= active ? slice[OW_UIO +: 8] : '0;
            pad_uio_oe  <= active ? slice[OW_OE +: 8]  : '0;
        end
    end
`else
    assign pad_uo_out  = active ? slice[OW_UO +: 8]  : '0;
    assign pad_uio_out = active ? slice[OW_UIO +: 8] : '0;
    assign pad_uio_oe  = active ? slice[OW_OE +: 8]  : '0;
`endif

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// Directed bench for tt_proj_mux_ctrl (default parameters, N_PROJ=16).
module tb_tt_proj_mux_ctrl;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel_rst = 1'b0;
    logic          sel_inc = 1'b0;
    logic          user_clk = 1'b0;
    logic          user_rst_n = 1'b1;
    logic [7:0]    pad_ui_in = 8'h3C;
    logic [7:0]    pad_uio_in = 8'h96;
    logic [17:0]   proj_iw;
    logic [N-1:0]  proj_ena;
    logic [24*N-1:0] proj_ow;
    logic [7:0]    pad_uo_out;
    logic [7:0]    pad_uio_out;
    logic [7:0]    pad_uio_oe;
    logic [3:0]    sel_idx;
    logic          active;

    int checks = 0;
    int failures = 0;
    int exp_idx;
    logic [17:0] exp_iw;
    logic [23:0] reg_zero_or;

    tt_proj_mux_ctrl #(
        .N_PROJ     (16),
        .SEL_W      (4),
        .SETTLE_CYC (4),
        .RST_CYC    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel_rst     (sel_rst),
        .sel_inc     (sel_inc),
        .user_clk    (user_clk),
        .user_rst_n  (user_rst_n),
        .pad_ui_in   (pad_ui_in),
        .pad_uio_in  (pad_uio_in),
        .proj_iw     (proj_iw),
        .proj_ena    (proj_ena),
        .proj_ow     (proj_ow),
        .pad_uo_out  (pad_uo_out),
        .pad_uio_out (pad_uio_out),
        .pad_uio_oe  (pad_uio_oe),
        .sel_idx     (sel_idx),
        .active      (active)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ow_val(input int k);
        if (k == 5) return 24'hA5C3F0;
        return {8'(8'h10 + k), 8'(8'h40 + k), 8'(8'h80 + k)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise sel_inc for 3 clocks: on return the edge has just been acted on
    task automatic inc_edge();
        sel_inc = 1'b1;
        tick_n(3);
        sel_inc = 1'b0;
    endtask

    task automatic rst_edge();
        sel_rst = 1'b1;
        tick_n(3);
        sel_rst = 1'b0;
    endtask

    function automatic logic [31:0] pads();
        return 32'({pad_uio_oe, pad_uio_out, pad_uo_out});
    endfunction

    initial begin
        for (int k = 0; k < N; k++) proj_ow[k*24 +: 24] = ow_val(k);

        // Reset state
        tick_n(2);
        rst = 1'b0;
        chk("rst_sel", 32'(sel_idx), 0);
        chk("rst_ena", 32'(proj_ena), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_pads", pads(), 0);
        user_clk = 1'b1;
        #1;
        exp_iw = {8'h96, 8'h3C, 1'b0, 1'b1};
        chk("iw_pass", 32'(proj_iw), 32'(exp_iw));
        user_clk = 1'b0;

        // Single select pulse: settle, reset, active
        inc_edge();
        chk("t1_sel", 32'(sel_idx), 1);
        chk("t1_sw_ena0", 32'(proj_ena), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_sw_ena", 32'(proj_ena), 0);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_rs_ena", 32'(proj_ena), 32'h2);
            chk("t1_rs_rstn", 32'(proj_iw[1]), 0);
            chk("t1_rs_pads", pads(), 0);
        end
        tick();
        chk("t1_active", 32'(active), 1);
        chk("t1_act_ena", 32'(proj_ena), 32'h2);
        chk("t1_act_rstn", 32'(proj_iw[1]), 1);
`ifdef TT_MUX_OUT_REG_EN
        reg_zero_or = 24'h0;
`else
        reg_zero_or = ow_val(1);
`endif
        chk("t1_pads_first", pads(), 32'(reg_zero_or));
        user_rst_n = 1'b0;
        #1;
        chk("t1_rstn_track", 32'(proj_iw[1]), 0);
        user_rst_n = 1'b1;
        tick();
        chk("t1_pads", pads(), 32'(ow_val(1)));

        // Wrap: 17 pulses from index 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_idx = 0;
        for (int p = 0; p < 17; p++) begin
            inc_edge();
            exp_idx = (exp_idx + 1) % N;
            chk("wrap_sel", 32'(sel_idx), 32'(exp_idx));
            for (int t = 0; t < 11; t++) begin
                tick();
                chk("wrap_onehot", 32'($onehot0(proj_ena)), 1);
            end
            tick();
            chk("wrap_act_ena", 32'(proj_ena), 32'(1) << exp_idx);
        end
        chk("wrap_end", 32'(sel_idx), 1);

        // Project 5 output word
        for (int p = 0; p < 4; p++) begin
            inc_edge();
            if (p < 3) tick_n(2);
        end
        chk("p5_sel", 32'(sel_idx), 5);
        chk("p5_pads_sw", pads(), 0);
        for (int t = 0; t < 11; t++) begin
            tick();
            chk("p5_pads_zero", pads(), 0);
            chk("p5_ena", 32'(proj_ena), (t < 3) ? 32'h0 : 32'h20);
        end
        tick();
        chk("p5_active", 32'(active), 1);
`ifdef TT_MUX_OUT_REG_EN
        reg_zero_or = 24'h0;
`else
        reg_zero_or = 24'hA5C3F0;
`endif
        chk("p5_pads_first", pads(), 32'(reg_zero_or));
        tick();
        chk("p5_oe", 32'(pad_uio_oe), 32'hA5);
        chk("p5_uio", 32'(pad_uio_out), 32'hC3);
        chk("p5_uo", 32'(pad_uo_out), 32'hF0);

        // Leave ACTIVE, then interrupt RESET in its third cycle
        inc_edge();
`ifdef TT_MUX_OUT_REG_EN
        reg_zero_or = 24'hA5C3F0;
`else
        reg_zero_or = 24'h0;
`endif
        chk("fall_pads_first", pads(), 32'(reg_zero_or));
        tick();
        chk("fall_pads", pads(), 0);
        tick_n(3);
        chk("t4_rs_ena", 32'(proj_ena), 32'h40);
        inc_edge();
        chk("t4_sel", 32'(sel_idx), 7);
        chk("t4_ena0", 32'(proj_ena), 0);
        for (int t = 0; t < 11; t++) begin
            tick();
            chk("t4_restart_ena", 32'(proj_ena), (t < 3) ? 32'h0 : 32'h80);
            chk("t4_restart_rstn", 32'(proj_iw[1]), 0);
        end
        tick();
        chk("t4_active", 32'(active), 1);
        chk("t4_act_ena", 32'(proj_ena), 32'h80);

        // Synchronous reset while ACTIVE on index 7
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_ena", 32'(proj_ena), 0);
        chk("t6_sel", 32'(sel_idx), 0);
        chk("t6_active", 32'(active), 0);
        chk("t6_pads", pads(), 0);
        tick();
        chk("t6_idle_ena", 32'(proj_ena), 0);
        chk("t6_idle_active", 32'(active), 0);

        // Simultaneous sel_rst and sel_inc at index 3
        for (int p = 0; p < 3; p++) begin
            inc_edge();
            tick_n(2);
        end
        chk("t5_sel3", 32'(sel_idx), 3);
        sel_rst = 1'b1;
        sel_inc = 1'b1;
        tick_n(3);
        sel_rst = 1'b0;
        sel_inc = 1'b0;
        chk("t5_both_sel", 32'(sel_idx), 0);
        chk("t5_both_ena", 32'(proj_ena), 0);
        tick_n(12);
        chk("t5_active", 32'(active), 1);
        chk("t5_act_ena", 32'(proj_ena), 32'h1);

        // sel_rst at index 0 still restarts the hand-over
        rst_edge();
        chk("t5_rst0_sel", 32'(sel_idx), 0);
        chk("t5_rst0_active", 32'(active), 0);
        chk("t5_rst0_ena", 32'(proj_ena), 0);
        tick_n(12);
        chk("t5_rst0_reactive", 32'(active), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
